rr_stream_arbiter: RTL and testbench

Parametrised N-channel round-robin stream arbiter that merges first-word-fall-through FIFO outputs (TLU, TDC, seq_gen readback, etc.) into one registered stream feeding the BRAM/SRAM output FIFO. It generalises the fixed two-channel merge used in the TLU readout path. New capabilities are a configurable channel count and data width, a budget-limited burst hold per channel, a registered valid/ready output stage, and optional channel-ID tagging.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/rr_stream_arbiter_pick.sv | 37 +++
 rtl/rr_stream_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and elaboration-time helpers for the round-robin stream arbiter.
// Holds the arbitration FSM encoding and the channel-index sizing helpers.
package rr_arb_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_ID_BITS  = 4;

    typedef logic [MAX_ID_BITS-1:0] ch_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A lone channel still needs a one-bit index so ports never collapse to zero width.
    function automatic int id_bits(input int channels);
        return (channels < 2) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_pick.sv
// Combinational rotating-priority picker: first requester at or after start_i wins.
// Produces a one-hot grant, the winning index and a valid flag.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int            pos;
    logic [IW-1:0] sel_pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        sel_pos = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel_pos = IW'(pos);
            if (!valid_o && req_i[sel_pos]) begin
                valid_o          = 1'b1;
                grant_o[sel_pos] = 1'b1;
                idx_o            = sel_pos;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-channel round-robin stream arbiter with burst hold and a registered output stage.
// Optional channel-ID tagging of the top DATA_OUT bits: define RR_ARB_CHANNEL_TAG_EN.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int  CHANNELS   = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 4,
    localparam int ID_BITS    = id_bits(CHANNELS)
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [CHANNELS-1:0]            WRITE_REQ,
    input  logic [CHANNELS-1:0]            HOLD_REQ,
    input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
    output logic [CHANNELS-1:0]            READ_GRANT,
    input  logic                           READY_OUT,
    output logic                           WRITE_OUT,
    output logic [DATA_WIDTH-1:0]          DATA_OUT,
    output logic [ID_BITS-1:0]             CURRENT_CH,
    output logic                           DBG_STATE
);

    // Valid/ready: a word moves downstream on any edge where WRITE_OUT && READY_OUT;
    // the output register may reload (load) whenever it is empty or being drained.

    arb_state_e state_q, state_d;
    logic [ID_BITS-1:0]    last_ch_q, last_ch_d;
    logic [ID_BITS-1:0]    lock_ch_q, lock_ch_d;
    logic [ID_BITS-1:0]    cur_ch_q, cur_ch_d;
    logic                  write_out_q, write_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  load;
    logic [CHANNELS-1:0]   eligible;
    logic [ID_BITS-1:0]    rr_start;
    logic [ID_BITS-1:0]    pick_start;
    logic [CHANNELS-1:0]   pick_grant;
    logic [ID_BITS-1:0]    pick_idx;
    logic                  pick_valid;
    logic                  hold_lock;
    logic                  lock_exit;
    logic                  burst_last;
    logic                  cnt_start;
    logic                  cnt_inc;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] sel_word;
    logic [DATA_WIDTH-1:0] din_arr [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_din
        assign din_arr[g] = DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign load      = !write_out_q || READY_OUT;
    assign hold_lock = HOLD_REQ[lock_ch_q];

    always_comb begin
        rr_start = '0;
        if (int'(last_ch_q) < CHANNELS - 1) begin
            rr_start = last_ch_q + ID_BITS'(1);
        end
    end

    // While locked only the owner may be served; its own index is the start point.
    always_comb begin
        eligible   = WRITE_REQ;
        pick_start = rr_start;
        if (state_q == ST_LOCK) begin
            eligible   = WRITE_REQ & (CHANNELS'(1) << lock_ch_q);
            pick_start = lock_ch_q;
        end
    end

    rr_priority_pick #(
        .N  (CHANNELS),
        .IW (ID_BITS)
    ) u_pick (
        .req_i   (eligible),
        .start_i (pick_start),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign READ_GRANT = (RST_N && load) ? pick_grant : '0;

    always_comb begin
`ifdef RR_ARB_CHANNEL_TAG_EN
        sel_word = {pick_idx, din_arr[pick_idx][DATA_WIDTH-ID_BITS-1:0]};
`else
        sel_word = din_arr[pick_idx];
`endif
    end

    always_comb begin
        state_d   = state_q;
        last_ch_d = last_ch_q;
        lock_ch_d = lock_ch_q;
        cnt_start = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        lock_exit = 1'b0;
        if (load) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        last_ch_d = pick_idx;
                        // A one-word budget is spent by the word that would open the lock.
                        if (HOLD_REQ[pick_idx] && (MAX_BURST != 1)) begin
                            state_d   = ST_LOCK;
                            lock_ch_d = pick_idx;
                            cnt_start = 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (!hold_lock || (pick_valid && burst_last)) begin
                        lock_exit = 1'b1;
                    end else if (pick_valid) begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (lock_exit) begin
                state_d   = ST_IDLE;
                last_ch_d = lock_ch_q;
                cnt_clr   = 1'b1;
            end
        end
    end

    always_comb begin
        write_out_d = write_out_q;
        data_out_d  = data_out_q;
        cur_ch_d    = cur_ch_q;
        if (load) begin
            write_out_d = pick_valid;
            if (pick_valid) begin
                data_out_d = sel_word;
                cur_ch_d   = pick_idx;
            end
        end
    end

    if (MAX_BURST > 0) begin : g_burst
        localparam int CNT_W = clog2(MAX_BURST + 1);
        logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

        always_comb begin
            burst_cnt_d = burst_cnt_q;
            if (cnt_clr) begin
                burst_cnt_d = '0;
            end else if (cnt_start) begin
                burst_cnt_d = CNT_W'(1);
            end else if (cnt_inc && (int'(burst_cnt_q) < MAX_BURST)) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                burst_cnt_q <= '0;
            end else begin
                burst_cnt_q <= burst_cnt_d;
            end
        end

        // True when the word being served now uses up the remaining budget.
        assign burst_last = (int'(burst_cnt_q) + 1) >= MAX_BURST;
    end else begin : g_no_burst
        assign burst_last = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            last_ch_q   <= ID_BITS'(CHANNELS - 1);
            lock_ch_q   <= '0;
            cur_ch_q    <= '0;
            write_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_ch_q   <= last_ch_d;
            lock_ch_q   <= lock_ch_d;
            cur_ch_q    <= cur_ch_d;
            write_out_q <= write_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign WRITE_OUT  = write_out_q;
    assign DATA_OUT   = data_out_q;
    assign CURRENT_CH = cur_ch_q;
    assign DBG_STATE  = (state_q == ST_LOCK);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: queue-backed input FIFOs, a behavioural arbitration
// model and an expected-word scoreboard, directed scenarios then random traffic.
module tb_rr_stream_arbiter;
    import rr_arb_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int MB  = 4;
    localparam int IDB = 2;
`ifdef RR_ARB_CHANNEL_TAG_EN
    localparam logic [DW-1:0] TAG_EXP = 32'hBFFF_FFFF;
`else
    localparam logic [DW-1:0] TAG_EXP = 32'hFFFF_FFFF;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    write_req;
    logic [N-1:0]    hold_req;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    read_grant;
    logic            ready_out;
    logic            write_out;
    logic [DW-1:0]   data_out;
    logic [IDB-1:0]  current_ch;
    logic            dbg_state;
    logic [DW-1:0]   din_w [N];

    for (genvar g = 0; g < N; g++) begin : g_din
        assign data_in[g*DW +: DW] = din_w[g];
    end

    rr_stream_arbiter #(
        .CHANNELS   (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .WRITE_REQ  (write_req),
        .HOLD_REQ   (hold_req),
        .DATA_IN    (data_in),
        .READ_GRANT (read_grant),
        .READY_OUT  (ready_out),
        .WRITE_OUT  (write_out),
        .DATA_OUT   (data_out),
        .CURRENT_CH (current_ch),
        .DBG_STATE  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    logic [DW-1:0] fifo_q [N][$];
    logic [DW-1:0] exp_q [$];
    int            served_log [$];
    int            exp_seq [$];
    logic [N-1:0]  hold_v;
    logic          ready_v;
    bit            m_full;
    bit            m_locked;
    int            m_ch;
    int            m_lock;
    int            m_last;
    int            m_burst;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef RR_ARB_CHANNEL_TAG_EN
    function automatic logic [DW-1:0] tag_word(input logic [DW-1:0] w, input int c);
        logic [DW-1:0] keep_mask;
        keep_mask = {DW{1'b1}} >> IDB;
        return (w & keep_mask) | (DW'(c) << (DW - IDB));
    endfunction
`endif

    function automatic void model_reset();
        m_full   = 1'b0;
        m_locked = 1'b0;
        m_ch     = 0;
        m_lock   = 0;
        m_last   = N - 1;
        m_burst  = 0;
        exp_q.delete();
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        logic [N-1:0] wr;
        wr = '0;
        for (int c = 0; c < N; c++) begin
            if (fifo_q[c].size() != 0) begin
                wr       = wr | (N'(1) << c);
                din_w[c] = fifo_q[c][0];
            end else begin
                din_w[c] = '0;
            end
        end
        write_req = wr;
        hold_req  = hold_v;
        ready_out = ready_v;
    endtask

    task automatic push_words(input int c, input int count);
        for (int k = 0; k < count; k++) begin
            fifo_q[c].push_back($urandom);
        end
    endtask

    // One cycle per iteration, entered at a negedge: drive, check, advance the model.
    task automatic step(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            int           pick;
            bit           load;
            logic [N-1:0] exp_grant;
            logic [DW-1:0] w;
            drive();
            #1;
            load = !m_full || ready_v;
            pick = -1;
            if (m_locked) begin
                if (fifo_q[m_lock].size() > 0) pick = m_lock;
            end else begin
                for (int j = 1; j <= N; j++) begin
                    int c;
                    c = (m_last + j) % N;
                    if (pick < 0 && fifo_q[c].size() > 0) pick = c;
                end
            end
            if (!load) pick = -1;
            exp_grant = (pick >= 0) ? (N'(1) << pick) : '0;
            check("read_grant", 64'(read_grant), 64'(exp_grant));
            check("write_out", 64'(write_out), 64'(m_full));
            check("lock_state", 64'(dbg_state), 64'(m_locked));
            if (m_full) begin
                check("data_out", 64'(data_out), 64'(exp_q[0]));
                check("current_ch", 64'(current_ch), 64'(m_ch));
            end
            if (m_full && ready_v) begin
                served_log.push_back(int'(current_ch));
                void'(exp_q.pop_front());
            end
            if (load) begin
                if (pick >= 0) begin
                    w = fifo_q[pick].pop_front();
`ifdef RR_ARB_CHANNEL_TAG_EN
                    exp_q.push_back(tag_word(w, pick));
`else
                    exp_q.push_back(w);
`endif
                    m_full = 1'b1;
                    m_ch   = pick;
                    if (!m_locked) begin
                        m_last = pick;
                        if (hold_v[pick] && MB != 1) begin
                            m_locked = 1'b1;
                            m_lock   = pick;
                            m_burst  = 1;
                        end
                    end else begin
                        m_burst++;
                        if (!hold_v[m_lock] || (MB != 0 && m_burst == MB)) begin
                            m_locked = 1'b0;
                            m_last   = m_lock;
                        end
                    end
                end else begin
                    m_full = 1'b0;
                    if (m_locked && !hold_v[m_lock]) begin
                        m_locked = 1'b0;
                        m_last   = m_lock;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    // Asynchronous reset pulse starting between clock edges; returns at a negedge.
    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_write_out", 64'(write_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_current_ch", 64'(current_ch), 64'(0));
        check("rst_read_grant", 64'(read_grant), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(served_log.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i < served_log.size()) begin
                check(tag, 64'(served_log[i]), 64'(exp_seq[i]));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        hold_v    = '0;
        ready_v   = 1'b1;
        write_req = '1;
        hold_req  = '0;
        ready_out = 1'b1;
        for (int c = 0; c < N; c++) din_w[c] = $urandom;
        model_reset();

        #12;
        check("reset_read_grant", 64'(read_grant), 64'(0));
        check("reset_write_out", 64'(write_out), 64'(0));
        check("reset_data_out", 64'(data_out), 64'(0));
        check("reset_current_ch", 64'(current_ch), 64'(0));
        check("reset_lock_state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain round-robin across all channels.
        for (int c = 0; c < N; c++) push_words(c, 2);
        served_log.delete();
        step(10);
        exp_seq = {0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr_order");

        // Burst budget: channel 1 holds with 10 words, channel 2 competes.
        reset_dut();
        push_words(1, 10);
        push_words(2, 2);
        hold_v = 4'b0010;
        served_log.delete();
        step(12);
        hold_v = '0;
        step(5);
        exp_seq = {1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
        check_log("burst_order");

        // Downstream backpressure with a full output register.
        for (int c = 0; c < N; c++) push_words(c, 3);
        served_log.delete();
        ready_v = 1'b1;
        step(3);
        ready_v = 1'b0;
        step(5);
        ready_v = 1'b1;
        step(16);
        check("bp_words_delivered", 64'(served_log.size()), 64'(12));

        // Lock stall: channel 0 empties while holding, channel 3 waits.
        reset_dut();
        push_words(0, 2);
        push_words(3, 3);
        hold_v = 4'b0001;
        served_log.delete();
        step(8);
        hold_v = '0;
        step(8);
        exp_seq = {0, 0, 3, 3, 3};
        check_log("stall_order");

        // Channel tagging on an all-ones word from channel 2.
        fifo_q[2].push_back(32'hFFFF_FFFF);
        step(1);
        #1;
        check("tag_data_out", 64'(data_out), 64'(TAG_EXP));
        check("tag_current_ch", 64'(current_ch), 64'(2));
        step(3);

        // Random traffic, holds and backpressure.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (fifo_q[c].size() < 6 && $urandom_range(0, 99) < 35) begin
                    fifo_q[c].push_back($urandom);
                end
            end
            if ($urandom_range(0, 99) < 8) begin
                hold_v = hold_v ^ (N'(1) << $urandom_range(0, N - 1));
            end
            ready_v = ($urandom_range(0, 99) < 75);
            step(1);
        end

        // Reset in the middle of a stream, then channel 0 first again.
        hold_v  = '0;
        ready_v = 1'b1;
        for (int c = 0; c < N; c++) push_words(c, 2);
        step(2);
        check("pre_reset_write_out", 64'(write_out), 64'(1));
        for (int c = 0; c < N; c++) push_words(c, 1);
        reset_dut();
        step(1);
        #1;
        check("post_reset_write_out", 64'(write_out), 64'(1));
        check("post_reset_ch0_first", 64'(current_ch), 64'(0));

        // Drain everything.
        hold_v  = '0;
        ready_v = 1'b1;
        step(60);
        check("drain_write_out", 64'(write_out), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
